// File: rtl/set_bit_enumerator.sv
// Set-bit enumerator: walks the set bits of an accepted word,
// emitting one isolated bit and its index per output beat.
module set_bit_enumerator #(
    parameter  int WORD_WIDTH  = 8,
    localparam int INDEX_WIDTH = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   input_valid,
    output logic                   input_ready,
    input  logic [WORD_WIDTH-1:0]  input_word,
    output logic                   output_valid,
    input  logic                   output_ready,
    output logic [WORD_WIDTH-1:0]  output_onehot,
    output logic [INDEX_WIDTH-1:0] output_index,
    output logic                   output_last
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] EMIT = 1'b1;

    logic [0:0]            state;
    logic                  armed;
    logic [WORD_WIDTH-1:0] remaining;
    logic [WORD_WIDTH-1:0] lowest;
    logic [WORD_WIDTH-1:0] rest;
    logic [INDEX_WIDTH-1:0] lowest_idx;
    logic                  emit;

    assign lowest = remaining & (-remaining);
    assign rest   = remaining & (remaining - WORD_WIDTH'(1));
    assign emit   = (state == EMIT);

    // lowest is one-hot or zero, so OR-ing positions encodes it
    always_comb begin
        lowest_idx = '0;
        for (int i = 0; i < WORD_WIDTH; i++) begin
            if (lowest[i]) lowest_idx = lowest_idx | INDEX_WIDTH'(i);
        end
    end

    // armed holds input_ready low until the first edge after reset
    assign input_ready   = armed & ~emit;
    assign output_valid  = emit;
    assign output_onehot = emit ? lowest : '0;
    assign output_index  = emit ? lowest_idx : '0;
    assign output_last   = emit & (rest == '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            armed     <= 1'b0;
            remaining <= '0;
        end else begin
            armed <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (input_valid && armed) begin
                        remaining <= input_word;
                        state     <= EMIT;
                    end
                end
                EMIT: begin
                    if (output_ready) begin
                        remaining <= rest;
                        if (rest == '0) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_set_bit_enumerator.sv
// Bench for set_bit_enumerator: directed cases plus randomized
// words checked against a bit-position reference model.
module tb_set_bit_enumerator;

    logic       clock;
    logic       reset_n;
    logic       iv, ir, ov, ordy, ol;
    logic [7:0] iw, oh;
    logic [2:0] oi;
    logic       iv1, ir1, ov1, ordy1, ol1;
    logic [0:0] iw1, oh1, oi1;

    int checks = 0;
    int errors = 0;

    logic [7:0] obs_oh[$];
    int         obs_idx[$];
    bit         obs_last[$];

    set_bit_enumerator #(.WORD_WIDTH(8)) dut8 (
        .clock(clock), .reset_n(reset_n),
        .input_valid(iv), .input_ready(ir), .input_word(iw),
        .output_valid(ov), .output_ready(ordy),
        .output_onehot(oh), .output_index(oi), .output_last(ol)
    );

    set_bit_enumerator #(.WORD_WIDTH(1)) dut1 (
        .clock(clock), .reset_n(reset_n),
        .input_valid(iv1), .input_ready(ir1), .input_word(iw1),
        .output_valid(ov1), .output_ready(ordy1),
        .output_onehot(oh1), .output_index(oi1), .output_last(ol1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send_word(input logic [7:0] w);
        chk("ready_before_send", 64'(ir), 64'(1));
        iv = 1'b1;
        iw = w;
        step();
        iv = 1'b0;
        chk("first_beat_latency", 64'(ov), 64'(1));
    endtask

    // mode 0: always ready, 1: toggle 1/0, 2: random
    task automatic collect(input int mode);
        int         cyc = 0;
        bit         done = 0;
        bit         tog = 1;
        bit         stalled = 0;
        logic [7:0] poh = '0;
        logic [2:0] pidx = '0;
        logic       pl = 1'b0;
        obs_oh.delete();
        obs_idx.delete();
        obs_last.delete();
        while (!done && cyc < 64) begin
            if (stalled)
                chk("stall_hold", 64'({oh, oi, ol}), 64'({poh, pidx, pl}));
            chk("valid_in_emit", 64'(ov), 64'(1));
            case (mode)
                0: ordy = 1'b1;
                1: begin ordy = tog; tog = ~tog; end
                default: ordy = ($urandom_range(0, 7) != 0);
            endcase
            if (ordy) begin
                obs_oh.push_back(oh);
                obs_idx.push_back(int'(oi));
                obs_last.push_back(ol);
                done = ol;
                stalled = 0;
            end else begin
                stalled = 1;
                poh = oh;
                pidx = oi;
                pl = ol;
            end
            step();
            cyc++;
        end
        ordy = 1'b0;
        chk("word_completed", 64'(done), 64'(1));
    endtask

    task automatic expect_beats(input string tag, input logic [7:0] e_oh[$],
                                input int e_idx[$]);
        chk({tag, "_count"}, 64'(obs_oh.size()), 64'(e_oh.size()));
        for (int k = 0; k < e_oh.size() && k < obs_oh.size(); k++) begin
            chk({tag, "_onehot"}, 64'(obs_oh[k]), 64'(e_oh[k]));
            chk({tag, "_index"}, 64'(obs_idx[k]), 64'(e_idx[k]));
            chk({tag, "_last"}, 64'(obs_last[k]), 64'(k == e_oh.size() - 1));
        end
    endtask

    initial begin
        logic [7:0] e_oh[$];
        int         e_idx[$];

        reset_n = 1'b0;
        iv = 0; iw = '0; ordy = 0;
        iv1 = 0; iw1 = '0; ordy1 = 0;
        #2;
        chk("rst_ready", 64'(ir), 64'(0));
        chk("rst_valid", 64'(ov), 64'(0));
        chk("rst_outs", 64'({oh, oi, ol}), 64'(0));
        @(negedge clock);
        reset_n = 1'b1;
        chk("ready_low_before_edge", 64'(ir), 64'(0));
        step();
        chk("ready_after_release", 64'(ir), 64'(1));
        chk("idle_valid", 64'(ov), 64'(0));

        send_word(8'b0101_1000);
        collect(0);
        e_oh = '{8'h08, 8'h10, 8'h40};
        e_idx = '{3, 4, 6};
        expect_beats("w58", e_oh, e_idx);
        chk("ready_after_last", 64'(ir), 64'(1));
        chk("valid_after_last", 64'(ov), 64'(0));

        send_word(8'h00);
        collect(0);
        e_oh = '{8'h00};
        e_idx = '{0};
        expect_beats("w00", e_oh, e_idx);

        send_word(8'hFF);
        collect(1);
        e_oh = '{};
        e_idx = '{};
        for (int k = 0; k < 8; k++) begin
            e_oh.push_back(8'(1 << k));
            e_idx.push_back(k);
        end
        expect_beats("wff_toggle", e_oh, e_idx);

        send_word(8'h80);
        collect(0);
        e_oh = '{8'h80};
        e_idx = '{7};
        expect_beats("w80", e_oh, e_idx);

        iv1 = 1'b1;
        iw1 = 1'b1;
        chk("w1_ready", 64'(ir1), 64'(1));
        step();
        iv1 = 1'b0;
        chk("w1_beat", 64'({ov1, oh1, oi1, ol1}), 64'(4'b1101));
        ordy1 = 1'b1;
        step();
        ordy1 = 1'b0;
        chk("w1_back_idle", 64'({ov1, ir1}), 64'(2'b01));

        send_word(8'hFF);
        ordy = 1'b1;
        step();
        step();
        chk("mid_word_valid", 64'({ov, oi}), 64'({1'b1, 3'd2}));
        #1;
        reset_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(ov), 64'(0));
        chk("async_rst_outs", 64'({ir, oh, oi, ol}), 64'(0));
        ordy = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        step();
        chk("post_rst_idle", 64'({ir, ov}), 64'(2'b10));
        send_word(8'h01);
        collect(0);
        e_oh = '{8'h01};
        e_idx = '{0};
        expect_beats("post_rst_w01", e_oh, e_idx);

        for (int n = 0; n < 10000; n++) begin
            logic [7:0] w;
            logic [7:0] acc;
            int         pos[$];
            bit         seq_ok;
            bit         last_ok;
            w = 8'($urandom_range(0, 255));
            pos = '{};
            for (int b = 0; b < 8; b++)
                if (w[b]) pos.push_back(b);
            if (pos.size() == 0) pos.push_back(0);
            send_word(w);
            collect(2);
            acc = '0;
            seq_ok = 1;
            last_ok = 1;
            foreach (obs_oh[k]) begin
                acc = acc | obs_oh[k];
                if (k >= pos.size() || obs_idx[k] != pos[k]) seq_ok = 0;
                if (k > 0 && obs_idx[k] <= obs_idx[k-1]) seq_ok = 0;
                if (obs_last[k] != (k == obs_oh.size() - 1)) last_ok = 0;
            end
            chk("rand_count", 64'(obs_oh.size()), 64'(pos.size()));
            chk("rand_or", 64'(acc), 64'(w));
            chk("rand_ascending", 64'(seq_ok), 64'(1));
            chk("rand_last", 64'(last_ok), 64'(1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/set_bit_enumerator.md
SET_BIT_ENUMERATOR -- requirements
Module: set_bit_enumerator

Interface
REQ-001 The block SHALL have parameter WORD_WIDTH, default 8, giving the width of the input word (legal range 1 to 64).
REQ-002 The block SHALL derive INDEX_WIDTH = max(1, clog2(WORD_WIDTH)) internally; INDEX_WIDTH is not a port parameter.
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port input_valid, input, 1 bit: input_word is valid.
REQ-006 The block SHALL have port input_ready, output, 1 bit: the block accepts input_word this cycle.
REQ-007 The block SHALL have port input_word, input, WORD_WIDTH bits: the bitmask to enumerate.
REQ-008 The block SHALL have port output_valid, output, 1 bit: the output beat is valid.
REQ-009 The block SHALL have port output_ready, input, 1 bit: downstream accepts the output beat.
REQ-010 The block SHALL have port output_onehot, output, WORD_WIDTH bits: the isolated current set bit.
REQ-011 The block SHALL have port output_index, output, INDEX_WIDTH bits: the bit position of output_onehot.
REQ-012 The block SHALL have port output_last, output, 1 bit: this beat is the final beat for the current word.

Function
REQ-013 The block SHALL emit, for each accepted word, one output beat per set bit, in ascending bit order (rightmost 1 first).
REQ-014 The block SHALL have exactly two states, IDLE and EMIT, and hold a WORD_WIDTH-bit register "remaining".
REQ-015 In IDLE the block SHALL drive input_ready=1 and output_valid=0.
REQ-016 In EMIT the block SHALL drive input_ready=0 and output_valid=1.
REQ-017 An input handshake in IDLE (input_valid=1) SHALL load remaining=input_word and move to EMIT on the same edge; the first beat is valid in the next cycle (latency 1).
REQ-018 In EMIT, output_onehot SHALL equal remaining AND (two's-complement negation of remaining).
REQ-019 In EMIT, output_index SHALL equal the position of that bit.
REQ-020 In EMIT, output_last SHALL be 1 iff (remaining AND (remaining-1))==0.
REQ-021 On an output handshake (output_valid AND output_ready), remaining SHALL become remaining AND (remaining-1).
REQ-022 An output handshake with output_last=1 SHALL return the block to IDLE.
REQ-023 An accepted word equal to zero SHALL produce exactly one beat: onehot=0, index=0, last=1.
REQ-024 While output_valid=1 and output_ready=0, output_onehot, output_index and output_last SHALL hold stable.
REQ-025 All outputs SHALL be derived only from registered state, with no combinational path from any input port to any output port.
REQ-026 Throughput SHALL be max(popcount(word),1)+1 cycles per word under continuous output_ready=1.
REQ-027 For WORD_WIDTH=1, output_index SHALL be a constant 0 of width 1.

Reset
REQ-028 Asserting reset_n=0 SHALL immediately, without a clock edge, force state=IDLE, remaining=0, output_valid=0, input_ready=0, output_onehot=0, output_index=0 and output_last=0.
REQ-029 After reset_n deasserts, input_ready SHALL rise to 1 at the first rising clock edge, with the block in IDLE.
REQ-030 Reset asserted mid-word SHALL discard the remaining bits; no further beats for that word appear after reset.

Verification
REQ-031 The bench SHALL cover: W=8, input 8'b01011000, output_ready=1 -> beats (00001000,3,0),(00010000,4,0),(01000000,6,1); input_ready returns 1 one cycle after the last beat.
REQ-032 The bench SHALL cover: W=8, input 8'h00 -> single beat (00000000,0,1).
REQ-033 The bench SHALL cover: W=8, input 8'hFF with output_ready toggling 1/0 -> 8 beats, indices 0..7, outputs held stable on every stall cycle, last=1 only at index 7.
REQ-034 The bench SHALL cover: W=8, input 8'h80 -> single beat (10000000,7,1); W=1, input 1'b1 -> (1,0,1).
REQ-035 The bench SHALL cover: reset_n pulsed low after the 2nd beat of 8'hFF -> output_valid=0 immediately; after release, a new input 8'h01 yields only (00000001,0,1).
REQ-036 The bench SHALL cover: randomized words with random output_ready over 10k words -> OR of all onehots per word equals the word, beat count equals max(popcount,1), and indices are strictly ascending.
